// File: rtl/enemy_missle_ctl_pkg.sv
// rtl/enemy_missle_ctl_pkg.sv - shared game constants, missile FSM encodings, saturating add
package enemy_missle_ctl_pkg;

  localparam int SCREEN_HEIGHT = 768;
  localparam int SHIP_W        = 48;
  localparam int SHIP_H        = 64;
  localparam int SHIP_TOP      = SCREEN_HEIGHT - SHIP_H;
  localparam int MISSLE_W      = 10;
  localparam int MISSLE_H      = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARM    = 3'd1;
  localparam logic [2:0] ST_LAUNCH = 3'd2;
  localparam logic [2:0] ST_FALL   = 3'd3;
  localparam logic [2:0] ST_HIT    = 3'd4;

  // 12-bit sum clamped to the 11-bit coordinate range
  function automatic logic [10:0] sat_add11(input logic [10:0] a, input logic [10:0] b);
    logic [11:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[11] ? 11'h7FF : s[10:0];
  endfunction

endpackage

// File: rtl/enemy_missle_ctl_if.sv
// rtl/enemy_missle_ctl_if.sv - game-state inputs and draw/hit outputs of the enemy missile
interface enemy_missle_ctl_if;

  logic [10:0] enemy_xpos_in;
  logic [10:0] enemy_ypos_in;
  logic        enemy_alive;
  logic [10:0] ship_xpos_in;
  logic        ship_dead;
  logic        fire_enable;
  logic [10:0] xpos_out;
  logic [10:0] ypos_out;
  logic        on_out;
  logic        ship_hit;

  modport master (
    input  enemy_xpos_in, enemy_ypos_in, enemy_alive, ship_xpos_in, ship_dead, fire_enable,
    output xpos_out, ypos_out, on_out, ship_hit
  );

  modport slave (
    output enemy_xpos_in, enemy_ypos_in, enemy_alive, ship_xpos_in, ship_dead, fire_enable,
    input  xpos_out, ypos_out, on_out, ship_hit
  );

endinterface

// File: rtl/enemy_missle_ctl_lfsr16.sv
// rtl/enemy_missle_ctl_lfsr16.sv - free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= SEED;
    else
      state <= {1'b0, state[15:1]} ^ (state[0] ? 16'hB400 : 16'h0000);
  end

endmodule

// File: rtl/enemy_missle_ctl.sv
// rtl/enemy_missle_ctl.sv - enemy missile: random cooldown, launch, fall, ship hit test
module enemy_missle_ctl
  import enemy_missle_ctl_pkg::*;
#(
  parameter int          STEP_LIMIT      = 90000,
  parameter int          COOLDOWN_BASE   = 65536,
  parameter logic [15:0] COOLDOWN_MASK   = 16'hFFFF,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter int          MISSLE_X_OFFSET = 19,
  parameter int          ENEMY_HEIGHT    = 64,
  parameter int          MISSLE_WIDTH    = MISSLE_W,
  parameter int          MISSLE_HEIGHT   = MISSLE_H,
  parameter int          SHIP_Y          = SHIP_TOP,
  parameter int          SHIP_WIDTH      = SHIP_W,
  parameter int          Y_BOTTOM        = 767
) (
  input logic                pclk,
  input logic                rst,
  enemy_missle_ctl_if.master bus
);

  localparam int          SW       = (STEP_LIMIT < 1) ? 1 : $clog2(STEP_LIMIT + 1);
  localparam logic [SW-1:0] STEP_MAX = SW'(STEP_LIMIT);
  localparam logic [16:0] CD_BASE  = 17'(COOLDOWN_BASE);
  localparam logic [10:0] X_OFS    = 11'(MISSLE_X_OFFSET);
  localparam logic [10:0] Y_OFS    = 11'(ENEMY_HEIGHT);
  localparam logic [11:0] MW12     = 12'(MISSLE_WIDTH);
  localparam logic [11:0] MH12     = 12'(MISSLE_HEIGHT);
  localparam logic [11:0] SY12     = 12'(SHIP_Y);
  localparam logic [11:0] SW12     = 12'(SHIP_WIDTH);
  localparam logic [10:0] YB11     = 11'(Y_BOTTOM);

  logic [2:0]    state;
  logic [SW-1:0] step;
  logic [16:0]   cooldown;
  logic [15:0]   lfsr;
  logic [10:0]   xpos, ypos;
  logic          on, hit_pulse;
  logic          trigger, hit;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(pclk), .rst(rst), .state(lfsr));

  assign trigger = bus.fire_enable && bus.enemy_alive && !bus.ship_dead;

  // Overlap test on the registered missile box against the ship box
  assign hit = (({1'b0, ypos} + MH12) >= SY12) &&
               (({1'b0, xpos} + MW12) > {1'b0, bus.ship_xpos_in}) &&
               ({1'b0, xpos} < ({1'b0, bus.ship_xpos_in} + SW12));

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      step      <= '0;
      cooldown  <= '0;
      xpos      <= '0;
      ypos      <= '0;
      on        <= 1'b0;
      hit_pulse <= 1'b0;
    end else begin
      hit_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          on <= 1'b0;
          if (trigger) begin
            state    <= ST_ARM;
            cooldown <= CD_BASE + {1'b0, lfsr & COOLDOWN_MASK};
          end
        end
        ST_ARM: begin
          if (bus.ship_dead || !bus.fire_enable)
            state <= ST_IDLE;
          else if (cooldown == '0)
            state <= bus.enemy_alive ? ST_LAUNCH : ST_IDLE;
          else
            cooldown <= cooldown - 17'd1;
        end
        ST_LAUNCH: begin
          xpos  <= sat_add11(bus.enemy_xpos_in, X_OFS);
          ypos  <= sat_add11(bus.enemy_ypos_in, Y_OFS);
          on    <= 1'b1;
          step  <= '0;
          state <= ST_FALL;
        end
        ST_FALL: begin
          if (step == STEP_MAX) begin
            step <= '0;
            ypos <= ypos + 11'd1;
          end else begin
            step <= step + 1'b1;
          end
          // ship death outranks a hit, a hit outranks reaching the bottom
          if (bus.ship_dead) begin
            state <= ST_IDLE;
            on    <= 1'b0;
          end else if (hit) begin
            state     <= ST_HIT;
            on        <= 1'b0;
            hit_pulse <= 1'b1;
          end else if (ypos >= YB11) begin
            state <= ST_IDLE;
            on    <= 1'b0;
          end
        end
        ST_HIT: begin
          on    <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.xpos_out = xpos;
  assign bus.ypos_out = ypos;
  assign bus.on_out   = on;
  assign bus.ship_hit = hit_pulse;

endmodule

// File: tb/tb_enemy_missle_ctl.sv
// tb/tb_enemy_missle_ctl.sv - directed vector bench for enemy_missle_ctl
module tb_enemy_missle_ctl;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  enemy_missle_ctl_if bus ();

  enemy_missle_ctl #(
    .STEP_LIMIT(3), .COOLDOWN_BASE(10), .COOLDOWN_MASK(16'h0000)
  ) dut (
    .pclk(pclk), .rst(rst), .bus(bus.master)
  );

  logic [15:0] lfsr_q;
  lfsr16 #(.SEED(16'hACE1)) u_lfsr (.clk(pclk), .rst(rst), .state(lfsr_q));

  typedef struct {
    int ex, ey, sx;
    int exp_x, exp_y0, exp_ylast, exp_hit;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    rst = 1'b0;
  endtask

  task automatic launch(input int ex, input int ey, input int sx, output int ok);
    int n;
    bus.enemy_xpos_in = 11'(ex);
    bus.enemy_ypos_in = 11'(ey);
    bus.ship_xpos_in  = 11'(sx);
    bus.enemy_alive   = 1'b1;
    bus.ship_dead     = 1'b0;
    bus.fire_enable   = 1'b1;
    n = 0;
    while (!bus.on_out && n < 60) begin
      @(negedge pclk);
      n++;
    end
    ok = bus.on_out ? 1 : 0;
  endtask

  task automatic fly(output int ylast, output int hit_at_drop, output int hits, output int ok);
    int n;
    n = 0;
    ylast = 0;
    hits = 0;
    while (bus.on_out && n < 4000) begin
      ylast = int'(bus.ypos_out);
      @(negedge pclk);
      n++;
    end
    ok = bus.on_out ? 0 : 1;
    hit_at_drop = int'(bus.ship_hit);
    for (int k = 0; k < 4; k++) begin
      hits += int'(bus.ship_hit);
      if (k == 0) bus.fire_enable = 1'b0;
      @(negedge pclk);
    end
  endtask

  vec_t vecs[$];

  initial begin
    int ok, ylast, hd, hits, cnt;
    logic [15:0] m;

    bus.enemy_xpos_in = '0;
    bus.enemy_ypos_in = '0;
    bus.ship_xpos_in  = '0;
    bus.enemy_alive   = 1'b0;
    bus.ship_dead     = 1'b0;
    bus.fire_enable   = 1'b0;

    vecs.push_back('{100,  200,  110, 119,  264,  688, 1});
    vecs.push_back('{100,  200,  300, 119,  264,  767, 0});
    vecs.push_back('{100,  200,  129, 119,  264,  767, 0});
    vecs.push_back('{100,  200,  128, 119,  264,  688, 1});
    vecs.push_back('{100,  200,   72, 119,  264,  688, 1});
    vecs.push_back('{100,  200,   71, 119,  264,  767, 0});
    vecs.push_back('{2040, 100,  300, 2047, 164,  767, 0});
    vecs.push_back('{500,  2000, 300, 519,  2047, 2047, 0});
    vecs.push_back('{100,  2000, 110, 119,  2047, 2047, 1});
    vecs.push_back('{100,  650,  110, 119,  714,  714, 1});

    do_reset();
    chk("rst_xpos", 32'(bus.xpos_out), 0);
    chk("rst_ypos", 32'(bus.ypos_out), 0);
    chk("rst_on",   32'(bus.on_out), 0);
    chk("rst_hit",  32'(bus.ship_hit), 0);

    // LFSR sequence against a reference Galois step
    m = 16'hACE1;
    chk("lfsr_seed", 32'(lfsr_q), 32'(m));
    for (int i = 0; i < 16; i++) begin
      @(negedge pclk);
      m = {1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0000);
      chk($sformatf("lfsr_step%0d", i), 32'(lfsr_q), 32'(m));
    end

    for (int i = 0; i < vecs.size(); i++) begin
      do_reset();
      launch(vecs[i].ex, vecs[i].ey, vecs[i].sx, ok);
      chk($sformatf("v%0d_launch", i), 32'(ok), 1);
      if (ok == 1) begin
        chk($sformatf("v%0d_x", i),  32'(bus.xpos_out), 32'(vecs[i].exp_x));
        chk($sformatf("v%0d_y0", i), 32'(bus.ypos_out), 32'(vecs[i].exp_y0));
        fly(ylast, hd, hits, ok);
        chk($sformatf("v%0d_end", i),   32'(ok), 1);
        chk($sformatf("v%0d_ylast", i), 32'(ylast), 32'(vecs[i].exp_ylast));
        chk($sformatf("v%0d_hitdrop", i), 32'(hd), 32'(vecs[i].exp_hit));
        chk($sformatf("v%0d_hits", i), 32'(hits), 32'(vecs[i].exp_hit));
      end
    end

    // y step cadence, then async reset mid-flight
    do_reset();
    launch(100, 200, 300, ok);
    chk("step_launch", 32'(ok), 1);
    cnt = 0;
    while (bus.on_out && bus.ypos_out == 11'd264 && cnt < 20) begin
      @(negedge pclk);
      cnt++;
    end
    chk("step_264_cycles", 32'(cnt), 4);
    cnt = 0;
    while (bus.on_out && bus.ypos_out == 11'd265 && cnt < 20) begin
      @(negedge pclk);
      cnt++;
    end
    chk("step_265_cycles", 32'(cnt), 4);
    #2 rst = 1'b1;
    #1;
    chk("arst_on",   32'(bus.on_out), 0);
    chk("arst_xpos", 32'(bus.xpos_out), 0);
    chk("arst_ypos", 32'(bus.ypos_out), 0);
    chk("arst_hit",  32'(bus.ship_hit), 0);
    hits = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge pclk);
      hits += int'(bus.ship_hit);
    end
    chk("arst_nohit", 32'(hits), 0);

    // ship_dead during ARM
    do_reset();
    bus.enemy_alive = 1'b1;
    bus.fire_enable = 1'b1;
    bus.ship_dead   = 1'b0;
    repeat (3) @(negedge pclk);
    bus.ship_dead = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge pclk);
      cnt += int'(bus.on_out) + int'(bus.ship_hit);
    end
    chk("dead_arm_quiet", 32'(cnt), 0);

    // ship_dead during FALL
    do_reset();
    launch(100, 200, 110, ok);
    chk("dead_fall_launch", 32'(ok), 1);
    repeat (10) @(negedge pclk);
    bus.ship_dead = 1'b1;
    @(negedge pclk);
    chk("dead_fall_on", 32'(bus.on_out), 0);
    hits = 0;
    for (int k = 0; k < 4; k++) begin
      hits += int'(bus.ship_hit);
      @(negedge pclk);
    end
    chk("dead_fall_nohit", 32'(hits), 0);

    // enemy gone when cooldown expires
    do_reset();
    bus.ship_dead   = 1'b0;
    bus.enemy_alive = 1'b1;
    bus.fire_enable = 1'b1;
    @(negedge pclk);
    bus.enemy_alive = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge pclk);
      cnt += int'(bus.on_out);
    end
    chk("no_enemy_nolaunch", 32'(cnt), 0);

    // hit and ship_dead in the same cycle: death wins
    do_reset();
    launch(100, 200, 110, ok);
    chk("tie_launch", 32'(ok), 1);
    cnt = 0;
    while (bus.ypos_out != 11'd688 && cnt < 3000) begin
      @(negedge pclk);
      cnt++;
    end
    chk("tie_reach688", 32'(bus.ypos_out), 688);
    bus.ship_dead = 1'b1;
    @(negedge pclk);
    chk("tie_on", 32'(bus.on_out), 0);
    hits = 0;
    for (int k = 0; k < 4; k++) begin
      hits += int'(bus.ship_hit);
      @(negedge pclk);
    end
    chk("tie_nohit", 32'(hits), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
